mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Arbitrates the single 8-bit RAM port between instruction fetch (IF) and data access (MEM).
- Serialises 32-bit fetches and 1/2/4-byte loads/stores into byte transfers.
- Raises if_stall_req_o / mem_stall_req_o to the pipeline stall controller for the duration of each access.
- Sits between the IF/MEM stages and the top-level RAM pins.

Parameters:
- ADDR_W, 32, width of all byte addresses.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- rdy  input  1  global ready; low freezes the block
- if_req_i  input  1  IF fetch request, held until if_done_o
- if_addr_i  input  ADDR_W  fetch address
- if_data_o  output  32  fetched word, valid with if_done_o
- if_done_o  output  1  one-cycle completion pulse
- if_stall_req_o  output  1  IF stall request to stall controller
- mem_req_i  input  1  MEM request, held until mem_done_o
- mem_we_i  input  1  1 = store, 0 = load
- mem_len_i  input  2  00 = byte, 01 = half, 10 = word
- mem_addr_i  input  ADDR_W  data address
- mem_wdata_i  input  32  store data, LSBs used
- mem_rdata_o  output  32  load data, zero-extended, valid with mem_done_o
- mem_done_o  output  1  one-cycle completion pulse
- mem_stall_req_o  output  1  MEM stall request
- ram_din_i  input  8  RAM read data, valid one cycle after the address
- ram_dout_o  output  8  RAM write data
- ram_a_o  output  ADDR_W  RAM byte address
- ram_wr_o  output  1  RAM write enable, 1 = write

Behaviour:
- Reset (async, rst=1):
  - state = IDLE, byte counter = 0.
  - All outputs 0: if_data_o, mem_rdata_o, done pulses, ram_a_o, ram_dout_o, ram_wr_o.
- States: IDLE, IF_RD, MEM_RD, MEM_WR, DONE.
- Byte count N: 1, 2 or 4 from mem_len_i; always 4 for IF.
- Byte order is little-endian: byte k at addr+k maps to data[8k+7:8k].
- IDLE:
  - Samples requests.
  - mem_req_i has priority over if_req_i when both are high.
  - On accept: latch addr, len, we and wdata; counter = 0; ram_a_o = addr.
  - For a store, ram_wr_o = 1 and ram_dout_o = wdata[7:0] in the first cycle.
- MEM_WR:
  - One byte per cycle; ram_wr_o high for exactly N consecutive cycles at addr..addr+N-1.
  - mem_done_o pulses the cycle after the last byte.
- IF_RD / MEM_RD:
  - Address addr+k is driven in cycle k.
  - ram_din_i is captured in cycle k+1 into byte k.
  - After N addresses, one extra capture cycle.
  - done pulses in the cycle after the last capture, i.e. N+2 cycles after the accept edge.
- DONE:
  - Lasts one cycle; the done pulse and valid data are presented here; then IDLE.
  - Data outputs hold their value until the next completion.
- Stall requests are combinational:
  - if_stall_req_o = if_req_i & ~if_done_o.
  - mem_stall_req_o = mem_req_i & ~mem_done_o.
  - While the other side is being served, the waiting side's stall request stays asserted.
- IF abort:
  - if_req_i low during IF_RD returns to IDLE at the next edge.
  - No if_done_o pulse and no RAM write. Used for branch flush.
- MEM accesses are never aborted.
- rdy = 0:
  - State, counter, ram_a_o and captured data are frozen; ram_wr_o forced to 0.
  - The held address keeps ram_din_i valid for the pending capture.
  - Operation resumes exactly where it stopped.
- A request still high in the IDLE cycle after DONE is treated as a new request.
- Address arithmetic wraps modulo 2^ADDR_W.
- ram_a_o and ram_dout_o are don't-care when ram_wr_o = 0 and in IDLE, but must be deterministic (hold last value).

Decomposition:
- Shared defines file (with the existing StallBus defines):
  - LenByte, LenHalf, LenWord encodings.
  - RamAddrBus, RamDataBus widths.
  - Controller state encodings.
- No sub-module. Byte assembly and the counter stay inline; the block is a single FSM plus datapath registers.

Test Plan:
- IF fetch only, addr 0x1000, RAM bytes 11,22,33,44 → ram_a_o 0x1000..0x1003 in 4 consecutive cycles; if_done_o in cycle 6 after accept; if_data_o = 0x44332211; if_stall_req_o high until done.
- Store word 0xDEADBEEF to 0x2000 → ram_wr_o high for 4 cycles with ram_dout_o EF,BE,AD,DE at 0x2000..0x2003; mem_done_o one cycle later.
- IF and MEM load half at 0x3002 (bytes 7F,80) raised in the same cycle → MEM served first with mem_rdata_o = 0x0000807F; IF served next; if_stall_req_o high throughout.
- IF fetch in progress, if_req_i dropped after 2 addresses → IDLE next cycle; no if_done_o; a new fetch at 0x4000 completes normally.
- rdy held low 3 cycles mid word load → no address advance and ram_wr_o = 0 during the freeze; data correct; done delayed exactly 3 cycles.
- rst asserted mid store → all outputs 0 immediately (asynchronously), before the next clock edge; no further ram_wr_o; next request after release starts cleanly.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the RAM-port controller: access lengths, bus widths, FSM states.
package mem_ctrl_pkg;

  localparam int StallBus   = 6;
  localparam int RamAddrBus = 32;
  localparam int RamDataBus = 8;

  typedef enum logic [1:0] {
    LenByte = 2'b00,
    LenHalf = 2'b01,
    LenWord = 2'b10
  } mem_len_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_IF_RD  = 3'd1,
    ST_MEM_RD = 3'd2,
    ST_MEM_WR = 3'd3,
    ST_DONE   = 3'd4
  } ctrl_state_e;

  // Encoding 2'b11 is unused by the pipeline and is treated as a word.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LenByte: len_bytes = 3'd1;
      LenHalf: len_bytes = 3'd2;
      default: len_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Serialises IF fetches and MEM loads/stores onto one byte-wide RAM port; MEM wins ties.
// Reads finish N+2 cycles after accept, stores N+1; rdy=0 freezes all state and masks ram_wr_o.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = RamAddrBus
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  if_req_i,
  input  logic [ADDR_W-1:0]     if_addr_i,
  output logic [31:0]           if_data_o,
  output logic                  if_done_o,
  output logic                  if_stall_req_o,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [1:0]            mem_len_i,
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic [31:0]           mem_wdata_i,
  output logic [31:0]           mem_rdata_o,
  output logic                  mem_done_o,
  output logic                  mem_stall_req_o,
  input  logic [RamDataBus-1:0] ram_din_i,
  output logic [RamDataBus-1:0] ram_dout_o,
  output logic [ADDR_W-1:0]     ram_a_o,
  output logic                  ram_wr_o
);

  ctrl_state_e           r_state, w_state_nxt;
  logic [2:0]            r_cnt, r_n;
  logic [31:0]           r_buf, w_buf, r_wdata, r_if_data, r_mem_rdata;
  logic                  r_if_done, r_mem_done, r_wr;
  logic [ADDR_W-1:0]     r_ram_a;
  logic [RamDataBus-1:0] r_dout;
  logic [1:0]            w_idx;
  logic                  w_last_rd, w_last_wr, w_abort;

  assign w_last_rd = (r_cnt == r_n);
  assign w_last_wr = (r_cnt == r_n - 3'd1);
  assign w_abort   = (r_state == ST_IF_RD) && !if_req_i;

  // Read data lags the address by one cycle, so count k holds byte k-1.
  always_comb begin
    w_buf = r_buf;
    w_idx = r_cnt[1:0] - 2'd1;
    w_buf[{w_idx, 3'b000} +: RamDataBus] = ram_din_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (mem_req_i)     w_state_nxt = mem_we_i ? ST_MEM_WR : ST_MEM_RD;
        else if (if_req_i) w_state_nxt = ST_IF_RD;
      end
      ST_IF_RD: begin
        if (w_abort)        w_state_nxt = ST_IDLE;
        else if (w_last_rd) w_state_nxt = ST_DONE;
      end
      ST_MEM_RD: if (w_last_rd) w_state_nxt = ST_DONE;
      ST_MEM_WR: if (w_last_wr) w_state_nxt = ST_DONE;
      default:   w_state_nxt = ST_IDLE;
    endcase
    if (!rdy) w_state_nxt = r_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_n         <= '0;
      r_buf       <= '0;
      r_wdata     <= '0;
      r_if_data   <= '0;
      r_mem_rdata <= '0;
      r_if_done   <= 1'b0;
      r_mem_done  <= 1'b0;
      r_wr        <= 1'b0;
      r_ram_a     <= '0;
      r_dout      <= '0;
    end else if (rdy) begin
      r_if_done  <= 1'b0;
      r_mem_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (mem_req_i || if_req_i) begin
            r_cnt   <= '0;
            r_buf   <= '0;
            r_n     <= mem_req_i ? len_bytes(mem_len_i) : 3'd4;
            r_ram_a <= mem_req_i ? mem_addr_i : if_addr_i;
            if (mem_req_i && mem_we_i) begin
              r_wr    <= 1'b1;
              r_dout  <= mem_wdata_i[7:0];
              r_wdata <= {8'h00, mem_wdata_i[31:8]};
            end
          end
        end
        ST_IF_RD, ST_MEM_RD: begin
          if (!w_abort) begin
            if (w_last_rd) begin
              if (r_state == ST_IF_RD) begin
                r_if_data <= w_buf;
                r_if_done <= 1'b1;
              end else begin
                r_mem_rdata <= w_buf;
                r_mem_done  <= 1'b1;
              end
            end else begin
              if (r_cnt != 3'd0) r_buf <= w_buf;
              if (!w_last_wr) r_ram_a <= r_ram_a + ADDR_W'(1);
              r_cnt <= r_cnt + 3'd1;
            end
          end
        end
        ST_MEM_WR: begin
          if (w_last_wr) begin
            r_wr       <= 1'b0;
            r_mem_done <= 1'b1;
          end else begin
            r_ram_a <= r_ram_a + ADDR_W'(1);
            r_dout  <= r_wdata[7:0];
            r_wdata <= {8'h00, r_wdata[31:8]};
            r_cnt   <= r_cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign if_data_o       = r_if_data;
  assign if_done_o       = r_if_done;
  assign mem_rdata_o     = r_mem_rdata;
  assign mem_done_o      = r_mem_done;
  assign ram_a_o         = r_ram_a;
  assign ram_dout_o      = r_dout;
  assign ram_wr_o        = r_wr & rdy;
  assign if_stall_req_o  = if_req_i & ~r_if_done;
  assign mem_stall_req_o = mem_req_i & ~r_mem_done;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: table of transactions plus hand sequences for tie, abort and reset.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam int K_IF = 0;
  localparam int K_LD = 1;
  localparam int K_ST = 2;

  typedef struct {
    int          kind;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_lat;
    int          frz_at;
    int          frz_len;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_data;
  logic        if_done, if_stall;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [1:0]  mem_len = 2'b00;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_done, mem_stall;
  logic [7:0]  ram_din = 8'h00;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;

  logic [7:0]  ram [0:65535];
  int          wr_cnt = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_data_o(if_data),
    .if_done_o(if_done), .if_stall_req_o(if_stall),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_len_i(mem_len),
    .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata), .mem_rdata_o(mem_rdata),
    .mem_done_o(mem_done), .mem_stall_req_o(mem_stall),
    .ram_din_i(ram_din), .ram_dout_o(ram_dout), .ram_a_o(ram_a), .ram_wr_o(ram_wr)
  );

  always #5 clk = ~clk;

  // Synchronous byte RAM on the global ready; the model aliases on the low 16 address bits.
  always @(posedge clk) begin
    if (rdy) begin
      ram_din <= ram[ram_a[15:0]];
      if (ram_wr) ram[ram_a[15:0]] = ram_dout;
    end
  end

  always @(negedge clk) if (ram_wr) wr_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int nb(input logic [1:0] len);
    return (len == LenByte) ? 1 : (len == LenHalf) ? 2 : 4;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int lat, act, p, n, wr0;
    bit seq_ok, stall_ok, dn, st;
    logic [31:0] sh, ea;
    n = (v.kind == K_IF) ? 4 : nb(v.len);
    if (v.kind == K_IF) begin
      if_req = 1'b1; if_addr = v.addr;
    end else begin
      mem_req = 1'b1; mem_we = (v.kind == K_ST); mem_len = v.len;
      mem_addr = v.addr; mem_wdata = v.wdata;
    end
    wr0 = wr_cnt; lat = 0; act = 0; seq_ok = 1'b1; stall_ok = 1'b1;
    for (int cyc = 1; cyc <= 40 && lat == 0; cyc++) begin
      if (rdy) act++;
      @(posedge clk); #1;
      if (cyc == v.frz_at) rdy = 1'b0;
      if (cyc == v.frz_at + v.frz_len) rdy = 1'b1;
      #1;
      dn = (v.kind == K_IF) ? if_done : mem_done;
      st = (v.kind == K_IF) ? if_stall : mem_stall;
      if (dn) begin
        lat = cyc;
        if (st) stall_ok = 1'b0;
      end else begin
        if (!st) stall_ok = 1'b0;
        p = act - 1;
        if (p < n) begin
          ea = v.addr + 32'(p);
          sh = v.wdata >> (8 * p);
          if (ram_a !== ea) seq_ok = 1'b0;
          if (ram_wr !== (v.kind == K_ST && rdy)) seq_ok = 1'b0;
          if (v.kind == K_ST && rdy && ram_dout !== sh[7:0]) seq_ok = 1'b0;
        end
      end
    end
    rdy = 1'b1;
    chk({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
    if (v.kind == K_IF) chk({tag, " if_data"}, if_data, v.exp_data);
    if (v.kind == K_LD) chk({tag, " mem_rdata"}, mem_rdata, v.exp_data);
    chk({tag, " ram sequence"}, 32'(seq_ok), 32'd1);
    chk({tag, " stall"}, 32'(stall_ok), 32'd1);
    chk({tag, " write count"}, 32'(wr_cnt - wr0), (v.kind == K_ST) ? 32'(n) : 32'd0);
    if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    @(posedge clk); #1;
  endtask

  vec_t tbl [12];
  vec_t v;
  int   mlat, ilat, cnt, wr1;
  bit   ok;
  logic [31:0] m_data;

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h1000] = 8'h11; ram[16'h1001] = 8'h22; ram[16'h1002] = 8'h33; ram[16'h1003] = 8'h44;
    ram[16'h3002] = 8'h7F; ram[16'h3003] = 8'h80;
    ram[16'h4000] = 8'hA1; ram[16'h4001] = 8'hB2; ram[16'h4002] = 8'hC3; ram[16'h4003] = 8'hD4;
    ram[16'h5000] = 8'h01; ram[16'h5001] = 8'h02; ram[16'h5002] = 8'h03; ram[16'h5003] = 8'h04;

    tbl[0]  = '{K_IF, LenWord, 32'h0000_1000, 32'h0,         32'h4433_2211, 6, 0, 0};
    tbl[1]  = '{K_ST, LenWord, 32'h0000_2000, 32'hDEAD_BEEF, 32'h0,         5, 0, 0};
    tbl[2]  = '{K_LD, LenWord, 32'h0000_2000, 32'h0,         32'hDEAD_BEEF, 6, 0, 0};
    tbl[3]  = '{K_LD, LenHalf, 32'h0000_3002, 32'h0,         32'h0000_807F, 4, 0, 0};
    tbl[4]  = '{K_LD, LenByte, 32'h0000_1003, 32'h0,         32'h0000_0044, 3, 0, 0};
    tbl[5]  = '{K_ST, LenByte, 32'h0000_5001, 32'h1234_56AB, 32'h0,         2, 0, 0};
    tbl[6]  = '{K_LD, LenWord, 32'h0000_5000, 32'h0,         32'h0403_AB01, 6, 0, 0};
    tbl[7]  = '{K_ST, LenHalf, 32'hFFFF_FFFF, 32'h0000_CAFE, 32'h0,         3, 0, 0};
    tbl[8]  = '{K_LD, LenHalf, 32'hFFFF_FFFF, 32'h0,         32'h0000_CAFE, 4, 0, 0};
    tbl[9]  = '{K_LD, LenWord, 32'h0000_1000, 32'h0,         32'h4433_2211, 9, 2, 3};
    tbl[10] = '{K_ST, LenWord, 32'h0000_6000, 32'h1122_3344, 32'h0,         7, 2, 2};
    tbl[11] = '{K_LD, LenWord, 32'h0000_6000, 32'h0,         32'h1122_3344, 6, 0, 0};

    // Asynchronous reset before any clock edge.
    #1 rst = 1'b1;
    #1;
    chk("reset if_data", if_data, 32'h0);
    chk("reset mem_rdata", mem_rdata, 32'h0);
    chk("reset if_done", 32'(if_done), 32'h0);
    chk("reset mem_done", 32'(mem_done), 32'h0);
    chk("reset ram_a", ram_a, 32'h0);
    chk("reset ram_dout", 32'(ram_dout), 32'h0);
    chk("reset ram_wr", 32'(ram_wr), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // IF and MEM raised together: MEM half load first, then the fetch.
    if_req = 1'b1; if_addr = 32'h1000;
    mem_req = 1'b1; mem_we = 1'b0; mem_len = LenHalf; mem_addr = 32'h3002;
    mlat = 0; ilat = 0; ok = 1'b1; m_data = '0;
    for (int cyc = 1; cyc <= 40 && ilat == 0; cyc++) begin
      @(posedge clk); #2;
      if (!if_done && !if_stall) ok = 1'b0;
      if (mem_done && mlat == 0) begin
        mlat = cyc; m_data = mem_rdata; mem_req = 1'b0;
      end
      if (if_done) ilat = cyc;
    end
    chk("tie mem latency", 32'(mlat), 32'd4);
    chk("tie mem data", m_data, 32'h0000_807F);
    chk("tie if latency", 32'(ilat), 32'd11);
    chk("tie if data", if_data, 32'h4433_2211);
    chk("tie if stall held", 32'(ok), 32'd1);
    chk("tie mem data held", mem_rdata, 32'h0000_807F);
    if_req = 1'b0;
    @(posedge clk); #1;

    // Fetch aborted after two addresses, then a clean fetch.
    if_req = 1'b1; if_addr = 32'h1000;
    wr1 = wr_cnt;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort second addr", ram_a, 32'h1001);
    if_req = 1'b0;
    cnt = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(posedge clk); #1;
      if (if_done) cnt++;
    end
    chk("abort no done", 32'(cnt), 32'd0);
    chk("abort no write", 32'(wr_cnt - wr1), 32'd0);
    chk("abort data held", if_data, 32'h4433_2211);
    v = '{K_IF, LenWord, 32'h0000_4000, 32'h0, 32'hD4C3_B2A1, 6, 0, 0};
    run_vec(v, "after abort");

    // Reset in the middle of a word store.
    mem_req = 1'b1; mem_we = 1'b1; mem_len = LenWord; mem_addr = 32'h7000; mem_wdata = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid store wr", 32'(ram_wr), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst ram_wr", 32'(ram_wr), 32'd0);
    chk("rst ram_a", ram_a, 32'h0);
    chk("rst ram_dout", 32'(ram_dout), 32'h0);
    chk("rst if_data", if_data, 32'h0);
    chk("rst mem_rdata", mem_rdata, 32'h0);
    mem_req = 1'b0; mem_we = 1'b0;
    wr1 = wr_cnt;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst no further write", 32'(wr_cnt - wr1), 32'd0);
    v = '{K_LD, LenWord, 32'h0000_2000, 32'h0, 32'hDEAD_BEEF, 6, 0, 0};
    run_vec(v, "after reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

endmodule
